mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Controller that sequences the registered multiply-accumulate datapath (a*b product + adder + enabled accumulator register) through one N-term dot-product job.
- Accepts a job with a length, clears the accumulator, and streams N operand pairs in over a valid/ready handshake.
- Gates the accumulator enable once per accepted pair.
- Captures the final sum and holds it until acknowledged.
- Sits between the job issuer/operand source and the MAC datapath; it drives the datapath's enable and clear.

Parameters:
WIDTH, 4, operand width of the MAC; accumulator and result are 2*WIDTH bits
CNT_W, 8, width of the job length field; max job length 2**CNT_W-1
TIMEOUT, 16, stall limit in cycles; used only when MAC_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
len  input  CNT_W  number of operand pairs for the job; latched on accepted start
busy  output  1  high in every state except IDLE
in_valid  input  1  operand pair (a,b) presented to the datapath this cycle
in_ready  output  1  controller accepts a pair this cycle
mac_en  output  1  accumulator enable to the datapath
mac_clr  output  1  synchronous accumulator clear to the datapath
sum_q  input  2*WIDTH  accumulator register output from the datapath
result  output  2*WIDTH  captured final sum
done  output  1  result valid; held until result_ack
result_ack  input  1  consumer acknowledges result; meaningful only when done=1

Behaviour:
- Synchronous active-high reset, including mid-job. State goes to IDLE. busy, in_ready, mac_en, mac_clr and done = 0. result = 0. Remaining count = 0.
- States: IDLE, CLR, RUN, DRAIN, DONE. Registered state; outputs decoded from state plus the handshake.
- IDLE: start=1 latches len into rem and goes to CLR. start=0 stays in IDLE.
- CLR (one cycle): mac_clr=1. If rem==0, go to DRAIN; else go to RUN.
- RUN: in_ready=1 and mac_en = in_valid (combinational, same cycle).
- RUN handshake (in_valid & in_ready): the pair is accumulated at that clock edge and rem decrements. When rem goes 1->0, go to DRAIN. No handshake: hold state and rem.
- DRAIN (one cycle): sum_q now reflects the last accumulation. result <= sum_q at the end of the cycle, then go to DONE. in_ready=0 and mac_en=0.
- DONE: done=1 and result is stable. result_ack=1 returns to IDLE; done drops the next cycle.
- start is ignored outside IDLE. A new job can be accepted no earlier than the cycle after leaving DONE.
- Latency: start to done = N+3 cycles with in_valid held high (1 IDLE edge, 1 CLR, N RUN, 1 DRAIN). len=0 gives done 3 cycles after start, with result=0.
- Arithmetic: accumulation wraps modulo 2**(2*WIDTH) in the datapath. The controller never saturates; result is sum_q verbatim.
- mac_en and mac_clr are never high together. mac_en is never high outside RUN.

Optional Feature:
MAC_TIMEOUT_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - In RUN, a stall counter increments each cycle without a handshake and clears on any handshake.
  - When it reaches TIMEOUT, go to DRAIN with err latched to 1. The partial sum is captured as result.
  - err clears on the transition DONE->IDLE.
- Not defined: no err port, no stall counter. RUN waits indefinitely for in_valid.

Test Plan:
- WIDTH=4, start len=3, pairs (2,3),(4,5),(15,15) with in_valid held high -> mac_en high exactly 3 cycles; done 6 cycles after start; result=251.
- start len=0 -> mac_clr pulses once; mac_en never asserts; done 3 cycles after start; result=0.
- len=2, pairs (3,3),(7,2) with in_valid low for 5 cycles between them -> in_ready high throughout RUN; mac_en only on the 2 handshake cycles; result=23.
- During DONE (result=23): assert start with len=4 and hold result_ack=0 for 10 cycles -> done and result stay stable, start ignored. Then result_ack=1 -> IDLE next cycle, done=0.
- reset=1 in RUN after 1 of 3 pairs -> next cycle busy=0, in_ready=0, done=0, result=0. A following len=1 job with (5,5) gives result=25 (the accumulator was cleared by CLR).
- MAC_TIMEOUT_EN, TIMEOUT=16: len=2, one pair (6,6), then in_valid low -> after 16 stall cycles DONE with err=1 and result=36. err=0 after ack.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a registered MAC datapath: clears the accumulator, streams N pairs, captures the sum.
// Optional stall timeout with err output enabled by defining MAC_TIMEOUT_EN.
module mac_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mac_en,
    output logic               mac_clr,
    input  logic [2*WIDTH-1:0] sum_q,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
`ifdef MAC_TIMEOUT_EN
    output logic               err,
`endif
    input  logic               result_ack
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             hs;

`ifdef MAC_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);
    logic [ST_W-1:0] stall;
`endif

    // in_ready is a registered flag that is high exactly while in RUN
    assign hs     = in_ready & in_valid;
    assign mac_en = hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            mac_clr  <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef MAC_TIMEOUT_EN
            err      <= 1'b0;
            stall    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem     <= len;
                        state   <= CLR;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                    end
                end
                CLR: begin
                    mac_clr <= 1'b0;
`ifdef MAC_TIMEOUT_EN
                    stall   <= '0;
`endif
                    if (rem == '0) begin
                        state <= DRAIN;
                    end else begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs) begin
                        rem <= rem - CNT_W'(1);
`ifdef MAC_TIMEOUT_EN
                        stall <= '0;
`endif
                        if (rem == CNT_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
`ifdef MAC_TIMEOUT_EN
                    // the TIMEOUT-th consecutive stall cycle abandons the job
                    else if (stall == ST_W'(TIMEOUT - 1)) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        stall <= stall + ST_W'(1);
                    end
`endif
                end
                DRAIN: begin
                    result <= sum_q;
                    state  <= DONE;
                    done   <= 1'b1;
                end
                DONE: begin
                    if (result_ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        busy  <= 1'b0;
`ifdef MAC_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    mac_clr  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a behavioural MAC datapath plus an arithmetic dot-product reference.
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    logic       mac_en;
    logic       mac_clr;
    logic [7:0] sum_q;
    logic [7:0] result;
    logic       done;
    logic       result_ack;
    logic [3:0] a, b;
`ifdef MAC_TIMEOUT_EN
    logic       err;
`endif

    int checks = 0;
    int fails  = 0;

    logic [3:0] pa[$];
    logic [3:0] pb[$];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.WIDTH(4), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .mac_en(mac_en), .mac_clr(mac_clr),
        .sum_q(sum_q), .result(result), .done(done),
`ifdef MAC_TIMEOUT_EN
        .err(err),
`endif
        .result_ack(result_ack)
    );

    // Environment: the registered MAC datapath the controller drives
    always_ff @(posedge clk) begin
        if (mac_clr)     sum_q <= '0;
        else if (mac_en) sum_q <= sum_q + 8'(a) * 8'(b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_sum(input int npres);
        int s = 0;
        for (int i = 0; i < npres; i++) s += int'(pa[i]) * int'(pb[i]);
        return 8'(s % 256);
    endfunction

    // Issues one job and streams the first npres queued pairs; returns when done rises or the budget expires
    task automatic run_job(input int n, input int npres, input int gap_at, input int gap_len,
                           input bit rnd_gap, output int lat, output int en_cnt,
                           output int clr_cnt, output int rdy_cnt, output int both);
        int idx  = 0;
        int gcnt = 0;
        lat = 0; en_cnt = 0; clr_cnt = 0; rdy_cnt = 0; both = 0;
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 2000) begin
            in_valid = 1'b0;
            if (in_ready && idx < npres) begin
                if (idx == gap_at && gcnt < gap_len) gcnt++;
                else if (rnd_gap && $urandom_range(3) == 0) in_valid = 1'b0;
                else begin
                    in_valid = 1'b1;
                    a = pa[idx];
                    b = pb[idx];
                end
            end
            #1;
            en_cnt  += int'(mac_en);
            clr_cnt += int'(mac_clr);
            rdy_cnt += int'(in_ready);
            if (mac_en && mac_clr) both++;
            if (in_valid && in_ready) idx++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("job_done_reached", 32'(done), 32'd1);
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_done_low", 32'(done), 32'd0);
        chk("ack_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, en_cnt, clr_cnt, rdy_cnt, both, n, st;
        logic [7:0] exp_sum;
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; result_ack = 1'b0;
        a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_mac_clr", 32'(mac_clr), 32'd0);

        // len=3, continuous valid
        pa = '{4'd2, 4'd4, 4'd15}; pb = '{4'd3, 4'd5, 4'd15};
        run_job(3, 3, -1, 0, 1'b0, lat, en_cnt, clr_cnt, rdy_cnt, both);
        chk("j1_latency", 32'(lat), 32'd6);
        chk("j1_mac_en_cycles", 32'(en_cnt), 32'd3);
        chk("j1_mac_clr_cycles", 32'(clr_cnt), 32'd1);
        chk("j1_result", 32'(result), 32'd251);
        chk("j1_overlap", 32'(both), 32'd0);
        ack();

        // len=0
        run_job(0, 0, -1, 0, 1'b0, lat, en_cnt, clr_cnt, rdy_cnt, both);
        chk("j0_latency", 32'(lat), 32'd3);
        chk("j0_mac_en_cycles", 32'(en_cnt), 32'd0);
        chk("j0_mac_clr_cycles", 32'(clr_cnt), 32'd1);
        chk("j0_result", 32'(result), 32'd0);
        ack();

        // len=2 with a 5-cycle bubble between the pairs
        pa = '{4'd3, 4'd7}; pb = '{4'd3, 4'd2};
        run_job(2, 2, 1, 5, 1'b0, lat, en_cnt, clr_cnt, rdy_cnt, both);
        chk("jg_latency", 32'(lat), 32'd10);
        chk("jg_in_ready_cycles", 32'(rdy_cnt), 32'd7);
        chk("jg_mac_en_cycles", 32'(en_cnt), 32'd2);
        chk("jg_result", 32'(result), 32'd23);

        // start while in DONE is ignored; result holds until acknowledged
        start = 1'b1; len = 8'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_result", 32'(result), 32'd23);
            chk("hold_mac_clr", 32'(mac_clr), 32'd0);
        end
        start = 1'b0;
        ack();
        tick();
        chk("post_ack_idle_busy", 32'(busy), 32'd0);

        // reset in RUN after one of three pairs
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        tick();
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = 4'd1; b = 4'd2;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        pa = '{4'd5}; pb = '{4'd5};
        run_job(1, 1, -1, 0, 1'b0, lat, en_cnt, clr_cnt, rdy_cnt, both);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_result", 32'(result), 32'd25);
        ack();

        // randomized jobs against the arithmetic reference
        for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(20, 1));
            pa.delete(); pb.delete();
            for (int i = 0; i < n; i++) begin
                pa.push_back(4'($urandom));
                pb.push_back(4'($urandom));
            end
            exp_sum = ref_sum(n);
            run_job(n, n, -1, 0, 1'b1, lat, en_cnt, clr_cnt, rdy_cnt, both);
            st = rdy_cnt - n;
            chk("rnd_result", 32'(result), 32'(exp_sum));
            chk("rnd_mac_en_cycles", 32'(en_cnt), 32'(n));
            chk("rnd_latency", 32'(lat), 32'(n + 3 + st));
            chk("rnd_overlap", 32'(both), 32'd0);
            ack();
        end

`ifdef MAC_TIMEOUT_EN
        // one pair of two, then the source stalls until the timeout fires
        pa = '{4'd6, 4'd1}; pb = '{4'd6, 4'd1};
        run_job(2, 1, -1, 0, 1'b0, lat, en_cnt, clr_cnt, rdy_cnt, both);
        chk("to_latency", 32'(lat), 32'd20);
        chk("to_err", 32'(err), 32'd1);
        chk("to_result", 32'(result), 32'd36);
        ack();
        chk("to_err_cleared", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
